stdp_pair_stim: RTL

STDP_PAIR_STIM -- requirements
Module: stdp_pair_stim

---
 rtl/stdp_pair_stim.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stdp_pair_stim.sv
// STDP pairing stimulator: drives timed current pulse pairs onto the pre- and
// postsynaptic neuron inputs, in causal or anti-causal order, for a
// configurable number of repetitions. All outputs come straight from flops.
module stdp_pair_stim (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] amp,
    input  logic [7:0] pulse_len,
    input  logic [7:0] gap_len,
    input  logic [7:0] rest_len,
    input  logic [7:0] n_pairs,
    input  logic       order,
    output logic [7:0] cur_pre,
    output logic [7:0] cur_post,
    output logic       busy,
    output logic       done,
    output logic [7:0] pair_idx
);

    typedef enum logic [2:0] {IDLE, FIRST, GAP, SECOND, REST, FINISH} state_t;

    // Phase slots inside one pair: 0 FIRST, 1 GAP, 2 SECOND, 3 REST; 4 = none left.
    localparam logic [2:0] NO_PHASE = 3'd4;

    state_t     state, nxt_state;
    logic [7:0] cnt, nxt_cnt, nxt_idx;
    logic [7:0] amp_q, pl_q, gl_q, rl_q, np_q;
    logic       order_q;

    logic       accept, load;
    logic [2:0] ph, cur_ph;
    logic [7:0] sel_pl, sel_gl, sel_rl, amp_sel;
    logic       ord_sel;

    // Lowest-numbered phase slot at or after 'from' with non-zero length.
    function automatic logic [2:0] find_phase(input logic [2:0] from, input logic [7:0] pl,
                                              input logic [7:0] gl, input logic [7:0] rl);
        logic [3:0][7:0] len;
        logic [2:0]      res;
        len = {rl, pl, gl, pl};
        res = NO_PHASE;
        for (int p = 3; p >= 0; p--) begin
            if (3'(p) >= from && len[p] != 8'd0) res = 3'(p);
        end
        return res;
    endfunction

    function automatic state_t phase_state(input logic [2:0] slot);
        case (slot)
            3'd0:    return FIRST;
            3'd1:    return GAP;
            3'd2:    return SECOND;
            default: return REST;
        endcase
    endfunction

    function automatic logic [7:0] phase_len(input logic [2:0] slot, input logic [7:0] pl,
                                             input logic [7:0] gl, input logic [7:0] rl);
        case (slot)
            3'd1:    return gl;
            3'd3:    return rl;
            default: return pl;
        endcase
    endfunction

    // Next-state decision: counts down the current phase and skips zero-length phases.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = pair_idx;
        accept    = 1'b0;
        load      = 1'b0;
        ph        = NO_PHASE;
        // In IDLE the run has not been latched yet, so decide from the live inputs.
        sel_pl    = (state == IDLE) ? pulse_len : pl_q;
        sel_gl    = (state == IDLE) ? gap_len   : gl_q;
        sel_rl    = (state == IDLE) ? rest_len  : rl_q;
        case (state)
            FIRST:   cur_ph = 3'd0;
            GAP:     cur_ph = 3'd1;
            SECOND:  cur_ph = 3'd2;
            default: cur_ph = 3'd3;
        endcase

        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    nxt_idx = 8'd0;
                    ph      = find_phase(3'd0, sel_pl, sel_gl, sel_rl);
                    if (n_pairs == 8'd0 || ph == NO_PHASE) nxt_state = FINISH;
                    else                                   load      = 1'b1;
                end
            end
            FIRST, GAP, SECOND, REST: begin
                if (cnt != 8'd1) begin
                    nxt_cnt = cnt - 8'd1;
                end else begin
                    ph = find_phase(cur_ph + 3'd1, sel_pl, sel_gl, sel_rl);
                    if (ph != NO_PHASE) begin
                        load = 1'b1;
                    end else if ({1'b0, pair_idx} + 9'd1 < {1'b0, np_q}) begin
                        nxt_idx = pair_idx + 8'd1;
                        ph      = find_phase(3'd0, sel_pl, sel_gl, sel_rl);
                        load    = 1'b1;
                    end else begin
                        nxt_state = FINISH;
                    end
                end
            end
            FINISH:  nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        if (load) begin
            nxt_state = phase_state(ph);
            nxt_cnt   = phase_len(ph, sel_pl, sel_gl, sel_rl);
        end

        amp_sel = accept ? amp   : amp_q;
        ord_sel = accept ? order : order_q;
    end

    // State, counters, latched config and registered outputs; ena low freezes the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the config registers are plain flops, so they are cleared with the FSM.
            state    <= IDLE;
            cnt      <= 8'd0;
            pair_idx <= 8'd0;
            amp_q    <= 8'd0;
            pl_q     <= 8'd0;
            gl_q     <= 8'd0;
            rl_q     <= 8'd0;
            np_q     <= 8'd0;
            order_q  <= 1'b0;
            cur_pre  <= 8'd0;
            cur_post <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (ena) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            pair_idx <= nxt_idx;
            if (accept) begin
                amp_q   <= amp;
                pl_q    <= pulse_len;
                gl_q    <= gap_len;
                rl_q    <= rest_len;
                np_q    <= n_pairs;
                order_q <= order;
            end
            busy     <= (nxt_state == FIRST) || (nxt_state == GAP) ||
                        (nxt_state == SECOND) || (nxt_state == REST);
            done     <= (nxt_state == FINISH);
            cur_pre  <= ((nxt_state == FIRST && !ord_sel) || (nxt_state == SECOND && ord_sel))
                        ? amp_sel : 8'd0;
            cur_post <= ((nxt_state == FIRST && ord_sel) || (nxt_state == SECOND && !ord_sel))
                        ? amp_sel : 8'd0;
        end else begin
            cur_pre  <= 8'd0;
            cur_post <= 8'd0;
            done     <= 1'b0;
        end
    end

endmodule
